// File: rtl/config_readback_if.sv
// Byte stream from config_readback to its sink.
// Valid/ready: a byte moves on a rising edge where tx_valid && tx_ready; once tx_valid
// is raised, tx_data and tx_valid hold until that accept, and tx_data reads 0 while idle.
interface config_readback_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/config_readback.sv
// Snapshots the tiles' exported config nibbles and streams them as a framed byte
// sequence: header, one byte per tile pair, then an XOR checksum of the data bytes.
module config_readback #(
  parameter int         NUM_TILES = 8,
  parameter logic [7:0] HEADER    = 8'hA5
) (
  input  logic                   CLK,
  input  logic                   resetn,
  input  logic [4*NUM_TILES-1:0] C_bits,
  input  logic                   start,
  config_readback_if.master      tx,
  output logic                   busy,
  output logic                   done,
  output logic                   drift,
  output logic [1:0]             state_dbg
);

  localparam int NUM_BYTES = NUM_TILES / 2;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEADER = 2'd1,
    S_DATA   = 2'd2,
    S_CHECK  = 2'd3
  } state_e;

  state_e                 state;
  logic [4*NUM_TILES-1:0] snapshot;
  logic [IDX_W-1:0]       idx;
  logic [7:0]             csum;
  logic [7:0]             tx_data_q;
  logic                   tx_valid_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   drift_q;
  logic                   accept;

  // Byte k packs tiles 2k (low nibble) and 2k+1 (high nibble), i.e. snapshot[8k +: 8].
  function automatic logic [7:0] pair_byte(input logic [4*NUM_TILES-1:0] snap,
                                           input logic [IDX_W-1:0]       k);
    return snap[8*int'(k) +: 8];
  endfunction

  assign accept = tx_valid_q & tx.tx_ready;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      snapshot   <= '0;
      idx        <= '0;
      csum       <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drift_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            snapshot   <= C_bits;
            drift_q    <= 1'b0;
            csum       <= '0;
            idx        <= '0;
            tx_data_q  <= HEADER;
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state      <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (accept) begin
            tx_data_q <= pair_byte(snapshot, '0);
            state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            csum <= csum ^ tx_data_q;
            if (idx == LAST_IDX) begin
              // Checksum byte folds in the byte being accepted right now.
              tx_data_q <= csum ^ tx_data_q;
              state     <= S_CHECK;
            end else begin
              idx       <= idx + 1'b1;
              tx_data_q <= pair_byte(snapshot, idx + 1'b1);
            end
          end
        end
        S_CHECK: begin
          if (accept) begin
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      // Sticky until the next accepted start; the frame content never follows live bits.
      if (state != S_IDLE && C_bits != snapshot) drift_q <= 1'b1;
    end
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign drift       = drift_q;
  assign state_dbg   = state;

endmodule

// File: doc/config_readback.md
CONFIG_READBACK -- requirements
Module: config_readback

Interface
REQ-001 Parameter NUM_TILES, default 8, number of tiles whose 4 exported configuration bits (C_bit0..C_bit3) are read back; SHALL be even and at least 2.
REQ-002 Parameter HEADER, default 8'hA5, header byte sent first in every frame.
REQ-003 Port CLK  input  1  the single clock; all state updates on the rising edge.
REQ-004 Port resetn  input  1  reset, asynchronous assertion, active-low.
REQ-005 Port C_bits  input  4*NUM_TILES  exported config bits; tile i occupies [4i+3:4i], with C_bit0 at bit 4i; quasi-static.
REQ-006 Port start  input  1  readback request, sampled only in IDLE.
REQ-007 Port tx_data  output  8  outgoing byte.
REQ-008 Port tx_valid  output  1  tx_data is valid.
REQ-009 Port tx_ready  input  1  the sink accepts the byte when tx_valid && tx_ready.
REQ-010 Port busy  output  1  high in every state except IDLE.
REQ-011 Port done  output  1  one-cycle pulse at frame completion.
REQ-012 Port drift  output  1  sticky flag: C_bits changed during the frame.

Function
REQ-013 The FSM SHALL have the states IDLE, HEADER, DATA and CHECK.
  - IDLE -> HEADER on start.
  - HEADER -> DATA on accept.
  - DATA -> CHECK on the accept of the last data byte.
  - CHECK -> IDLE on accept.
REQ-014 On the edge where start=1 in IDLE, the block SHALL capture C_bits into a snapshot register, clear drift, clear the checksum and zero the byte index.
REQ-015 tx_valid SHALL be high with tx_data=HEADER in the cycle after start is captured, giving one cycle of latency.
REQ-016 In DATA, byte k (k=0..NUM_TILES/2-1) SHALL be {snapshot tile 2k+1 bits, snapshot tile 2k bits}, with the odd tile in the upper nibble.
REQ-017 The byte index SHALL advance only on accept and SHALL be sized to ceil(log2(NUM_TILES/2)) bits, minimum 1 bit.
REQ-018 CHECK SHALL send the XOR of all data bytes; the header is excluded.
REQ-019 While tx_valid=1 and tx_ready=0, tx_data SHALL be held stable and tx_valid SHALL stay high.
  - tx_valid SHALL never drop before an accept.
REQ-020 tx_valid SHALL be continuously high in HEADER, DATA and CHECK, with no bubble between bytes when tx_ready is held at 1.
REQ-021 A frame SHALL be exactly NUM_TILES/2+2 bytes.
  - With tx_ready held at 1, the frame SHALL take exactly NUM_TILES/2+2 cycles from the first tx_valid.
REQ-022 done SHALL pulse high for exactly one cycle, registered, in the cycle after the CHECK byte is accepted; busy SHALL be 0 in that same cycle.
REQ-023 start asserted while busy=1 SHALL be ignored, with no restart, no new snapshot and no queuing.
REQ-024 start asserted in the done cycle SHALL begin a new frame normally, because the FSM is already in IDLE.
REQ-025 While busy=1, drift SHALL be set whenever live C_bits differ from the snapshot.
  - drift SHALL remain set until the next accepted start or reset.
  - The transmitted data SHALL always come from the snapshot.
REQ-026 tx_data SHALL be 8'h00 whenever tx_valid=0.

Reset
REQ-027 When resetn=0, asynchronously: FSM to IDLE; tx_valid, busy, done, drift, tx_data, the index, the checksum and the snapshot all 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately, with no done pulse.
  - After resetn rises, the block SHALL wait in IDLE for a fresh start.
REQ-029 start coincident with the first clock edge after reset release SHALL be accepted.

Verification
REQ-030 Basic frame: NUM_TILES=4, C_bits=16'h3C5A, tx_ready=1, start pulse.
  - Required response: bytes A5, 5A, 3C, 66 on consecutive cycles.
  - done pulses one cycle after the 66 byte; busy is high for 4 cycles.
REQ-031 Backpressure: same stimulus, with tx_ready low for 3 cycles on each byte.
  - Required response: each byte held stable while stalled, same 4-byte sequence, no duplicated bytes and no dropped bytes.
REQ-032 Drift: NUM_TILES=4, C_bits changed to 16'hFFFF while the 5A byte is stalled.
  - Required response: still A5, 5A, 3C, 66; drift=1 after the change.
  - drift clears on the next start.
REQ-033 start while busy: start pulsed during DATA.
  - Required response: the frame is unchanged, the byte count is 4 and done pulses exactly once.
REQ-034 Reset mid-frame: resetn driven low after the A5 byte is accepted.
  - Required response: all outputs 0 at once; after release, a new start gives a full A5... frame.
REQ-035 Default NUM_TILES=8 with C_bits all ones.
  - Required response: A5, FF, FF, FF, FF, 00.
